// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: press-command handshake and status between a test master and the keypad emulator
interface keypad_emulator_if;
  logic       press_valid;
  logic [3:0] press_key;
  logic       press_ready;
  logic       busy;
  logic       done;
  logic       err;
  modport master (output press_valid, press_key, input press_ready, busy, done, err);
  modport slave  (input press_valid, press_key, output press_ready, busy, done, err);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 3x3 matrix-keypad responder with bounce, hold and release-gap timing
module keypad_emulator #(
  parameter logic [23:0] HOLD_CYCLES   = 24'd6_000_000,
  parameter logic [15:0] BOUNCE_CYCLES = 16'd60_000,
  parameter logic [15:0] BOUNCE_PERIOD = 16'd6_000,
  parameter logic [23:0] GAP_CYCLES    = 24'd3_000_000
) (
  input  logic hwclk,
  input  logic reset,
  keypad_emulator_if.slave cmd,
  input  logic keypad_r1,
  input  logic keypad_r2,
  input  logic keypad_r3,
  output logic keypad_c1,
  output logic keypad_c2,
  output logic keypad_c3
);
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;
  localparam bit NO_BOUNCE = BOUNCE_CYCLES == 16'd0;
  localparam logic [23:0] BOUNCE_LOAD = 24'(BOUNCE_CYCLES) - 24'd1;
  localparam logic [23:0] HOLD_LOAD = HOLD_CYCLES - 24'd1;
  localparam logic [23:0] GAP_LOAD = GAP_CYCLES - 24'd1;
  state_t state, state_d;
  logic [23:0] cnt, cnt_d;
  logic [15:0] ph;
  logic contact, done_q, err_q;
  logic [1:0] row_q, col_q, row_k, col_k;
  logic [3:0] k1;
  logic key_ok, accept, last, row_low, hit;
  assign key_ok = cmd.press_key >= 4'd1 && cmd.press_key <= 4'd9;
  assign accept = state == IDLE && cmd.press_valid;
  assign last = cnt == 24'd0;
  assign k1 = cmd.press_key - 4'd1;
  assign row_k = k1 >= 4'd6 ? 2'd2 : k1 >= 4'd3 ? 2'd1 : 2'd0;
  assign col_k = 2'(k1 - 4'(row_k) * 4'd3);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:       if (accept && key_ok) state_d = NO_BOUNCE ? HOLD : BOUNCE_IN;
      BOUNCE_IN:  if (last) state_d = HOLD;
      HOLD:       if (last) state_d = NO_BOUNCE ? GAP : BOUNCE_OUT;
      BOUNCE_OUT: if (last) state_d = GAP;
      GAP:        if (last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    cnt_d = state_d != state ? (state_d == HOLD ? HOLD_LOAD : state_d == GAP ? GAP_LOAD :
                                state_d == IDLE ? 24'd0 : BOUNCE_LOAD)
          : state == IDLE ? cnt : cnt - 24'd1;
  end
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ph <= '0;
      contact <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      done_q <= (state == GAP && last) || (accept && !key_ok);
      err_q <= accept && !key_ok;
      if (accept && key_ok) begin
        row_q <= row_k;
        col_q <= col_k;
      end
      // each phase starts with a known contact level; bounce phases then chatter
      if (state_d != state) begin
        ph <= '0;
        contact <= state_d == BOUNCE_IN || state_d == HOLD;
      end else if (state == BOUNCE_IN || state == BOUNCE_OUT) begin
        ph <= ph == BOUNCE_PERIOD - 16'd1 ? 16'd0 : ph + 16'd1;
        if (ph == BOUNCE_PERIOD - 16'd1) contact <= ~contact;
      end
    end
  end
  assign cmd.press_ready = state == IDLE;
  assign cmd.busy = state != IDLE;
  assign cmd.done = done_q;
  assign cmd.err = err_q;
  assign row_low = row_q == 2'd0 ? !keypad_r1 : row_q == 2'd1 ? !keypad_r2 : !keypad_r3;
  assign hit = contact && row_low;
  assign keypad_c1 = !(hit && col_q == 2'd0);
  assign keypad_c2 = !(hit && col_q == 2'd1);
  assign keypad_c3 = !(hit && col_q == 2'd2);
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: drives a bounce-enabled and a bounce-free emulator against a per-cycle contact schedule model
module tb_keypad_emulator;
  logic hwclk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic [2:0] rows = 3'b111;
  bit scan = 1'b1;
  int sc = 0;
  wire [2:0] cols_a, cols_b;
  int total = 0, bad = 0;
  bit sched [2][32];
  int len [2], pos [2], mrow [2], mcol [2];
  bit mbusy [2], mcont [2], pend [2], mdone [2], merr [2];

  keypad_emulator_if if_a();
  keypad_emulator_if if_b();
  assign if_a.press_valid = valid;
  assign if_a.press_key = key;
  assign if_b.press_valid = valid;
  assign if_b.press_key = key;

  keypad_emulator #(.HOLD_CYCLES(24'd8), .BOUNCE_CYCLES(16'd4), .BOUNCE_PERIOD(16'd1), .GAP_CYCLES(24'd3)) dut_a (
    .hwclk(hwclk), .reset(reset), .cmd(if_a.slave),
    .keypad_r1(rows[0]), .keypad_r2(rows[1]), .keypad_r3(rows[2]),
    .keypad_c1(cols_a[0]), .keypad_c2(cols_a[1]), .keypad_c3(cols_a[2]));

  keypad_emulator #(.HOLD_CYCLES(24'd8), .BOUNCE_CYCLES(16'd0), .BOUNCE_PERIOD(16'd1), .GAP_CYCLES(24'd3)) dut_b (
    .hwclk(hwclk), .reset(reset), .cmd(if_b.slave),
    .keypad_r1(rows[0]), .keypad_r2(rows[1]), .keypad_r3(rows[2]),
    .keypad_c1(cols_b[0]), .keypad_c2(cols_b[1]), .keypad_c3(cols_b[2]));

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_cols(input int d);
    logic [2:0] e;
    for (int c = 0; c < 3; c++) e[c] = !(mcont[d] && mcol[d] == c && rows[mrow[d]] == 1'b0);
    return e;
  endfunction

  // contact level for every cycle of a command: bounce-in, hold, bounce-out, gap
  task automatic build(input int d);
    int b, n;
    b = d == 0 ? 4 : 0;
    n = 0;
    for (int i = 0; i < b; i++) sched[d][n++] = (i % 2) == 0;
    for (int i = 0; i < 8; i++) sched[d][n++] = 1'b1;
    for (int i = 0; i < b; i++) sched[d][n++] = (i % 2) == 1;
    for (int i = 0; i < 3; i++) sched[d][n++] = 1'b0;
    len[d] = n;
    pos[d] = 0;
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit was_busy;
      was_busy = mbusy[d];
      mdone[d] = 1'b0;
      merr[d] = 1'b0;
      if (reset) begin
        len[d] = 0; pos[d] = 0; mbusy[d] = 1'b0; mcont[d] = 1'b0; pend[d] = 1'b0;
        mrow[d] = 0; mcol[d] = 0;
      end else begin
        if (!was_busy && valid) begin
          if (key >= 1 && key <= 9) begin
            mrow[d] = (int'(key) - 1) / 3;
            mcol[d] = (int'(key) - 1) % 3;
            build(d);
          end else begin
            mdone[d] = 1'b1;
            merr[d] = 1'b1;
          end
        end
        if (pos[d] < len[d]) begin
          mcont[d] = sched[d][pos[d]];
          pos[d]++;
          mbusy[d] = 1'b1;
          if (pos[d] == len[d]) pend[d] = 1'b1;
        end else begin
          mcont[d] = 1'b0;
          mbusy[d] = 1'b0;
          if (pend[d]) begin
            mdone[d] = 1'b1;
            pend[d] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] k);
    valid = v;
    key = k;
    if (scan) begin
      rows = 3'b111 & ~(3'b001 << sc);
      sc = (sc + 1) % 3;
    end else rows = 3'($urandom);
    #1;
    chk("cols_a_mid", 8'(cols_a), 8'(exp_cols(0)));
    chk("cols_b_mid", 8'(cols_b), 8'(exp_cols(1)));
    @(posedge hwclk);
    model_edge();
    #1;
    chk("cols_a", 8'(cols_a), 8'(exp_cols(0)));
    chk("busy_a", 8'(if_a.busy), 8'(mbusy[0]));
    chk("ready_a", 8'(if_a.press_ready), 8'(!mbusy[0]));
    chk("done_a", 8'(if_a.done), 8'(mdone[0]));
    chk("err_a", 8'(if_a.err), 8'(merr[0]));
    chk("cols_b", 8'(cols_b), 8'(exp_cols(1)));
    chk("busy_b", 8'(if_b.busy), 8'(mbusy[1]));
    chk("ready_b", 8'(if_b.press_ready), 8'(!mbusy[1]));
    chk("done_b", 8'(if_b.done), 8'(mdone[1]));
    chk("err_b", 8'(if_b.err), 8'(merr[1]));
    @(negedge hwclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      len[d] = 0; pos[d] = 0; mrow[d] = 0; mcol[d] = 0;
      mbusy[d] = 0; mcont[d] = 0; pend[d] = 0; mdone[d] = 0; merr[d] = 0;
    end
    repeat (2) @(posedge hwclk);
    @(negedge hwclk);
    cycle(1'b0, 4'd0);
    reset = 1'b0;
    idle(6);
    cycle(1'b1, 4'd5);
    idle(22);
    cycle(1'b1, 4'd9);
    idle(22);
    cycle(1'b1, 4'd0);
    idle(2);
    cycle(1'b1, 4'd12);
    idle(2);
    cycle(1'b1, 4'd1);
    for (int i = 0; i < 30; i++) cycle(1'b1, 4'd7);
    idle(24);
    cycle(1'b1, 4'd4);
    idle(6);
    reset = 1'b1;
    cycle(1'b0, 4'd0);
    reset = 1'b0;
    idle(2);
    cycle(1'b1, 4'd2);
    idle(22);
    scan = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 149) == 0;
      cycle($urandom_range(0, 3) == 0, 4'($urandom));
    end
    reset = 1'b0;
    idle(24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
